ls_issue_sched: RTL

- Sequencer between the load/store queue and the data cache in the out-of-order core.
- Buffers up to DEPTH address-resolved load/store ops in order and issues them to the data cache one at a time.
- Waits for cache completion, then broadcasts load results on the common data bus (CDB) and acknowledges the cache.
- Stores complete silently, with no CDB broadcast.

---
 rtl/ls_issue_sched_if.sv | 53 +++++
 rtl/ls_issue_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ls_issue_sched_if.sv
// Bundle of the LSQ, data-cache and CDB signals around the load/store issue scheduler.
// master: scheduler side. slave: environment side (LSQ, data cache, CDB arbiter).
interface ls_issue_sched_if #(
    parameter int unsigned TAGW = 6
);
    // LSQ -> scheduler
    logic            lsq_valid;
    logic            lsq_ready;
    logic            lsq_opcode;
    logic [31:0]     lsq_address;
    logic [31:0]     lsq_data;
    logic [TAGW-1:0] lsq_tag;
    // Scheduler <-> data cache
    logic            dc_req;
    logic            dc_ready;
    logic            dc_opcode;
    logic [31:0]     dc_address;
    logic [31:0]     dc_data;
    logic [TAGW-1:0] dc_tag;
    logic            dc_done;
    logic [31:0]     dc_data_in;
    logic [TAGW-1:0] dc_tag_in;
    logic            dc_ack;
    // Scheduler -> CDB
    logic            cdb_req;
    logic            cdb_grant;
    logic [31:0]     cdb_data;
    logic [TAGW-1:0] cdb_tag;
    // Status
    logic            tag_err;
    logic [15:0]     ld_count;
    logic [15:0]     st_count;

    modport master (
        input  lsq_valid, lsq_opcode, lsq_address, lsq_data, lsq_tag,
        output lsq_ready,
        output dc_req, dc_opcode, dc_address, dc_data, dc_tag, dc_ack,
        input  dc_ready, dc_done, dc_data_in, dc_tag_in,
        output cdb_req, cdb_data, cdb_tag,
        input  cdb_grant,
        output tag_err, ld_count, st_count
    );

    modport slave (
        output lsq_valid, lsq_opcode, lsq_address, lsq_data, lsq_tag,
        input  lsq_ready,
        input  dc_req, dc_opcode, dc_address, dc_data, dc_tag, dc_ack,
        output dc_ready, dc_done, dc_data_in, dc_tag_in,
        input  cdb_req, cdb_data, cdb_tag,
        output cdb_grant,
        input  tag_err, ld_count, st_count
    );
endinterface

// File: rtl/ls_issue_sched.sv
// Load/store issue scheduler: in-order buffer between the LSQ and the data cache.
// Issues one op at a time, waits for completion, broadcasts load results on the CDB
// and acknowledges the cache. Stores complete without a broadcast.
// Optional completion counters are enabled with the macro LS_ISSUE_STAT_EN.
module ls_issue_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 6
) (
    input logic              clk,
    input logic              reset,
    ls_issue_sched_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    typedef struct packed {
        logic            op;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [TAGW-1:0] tag;
    } entry_t;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StBcast, StAck} state_e;

    state_e          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push, pop;
    logic            dc_req, cdb_req, dc_ack;
    logic            dc_op_q;
    logic [31:0]     dc_addr_q, dc_data_q, cdb_data_q;
    logic [TAGW-1:0] dc_tag_q, cdb_tag_q;
    logic            tag_err_q;

    // Ready only from the registered count so it never combinationally depends on a pop
    assign bus.lsq_ready = (count_q != FullCnt);
    assign push          = bus.lsq_valid && bus.lsq_ready;
    assign head          = mem_q[rd_ptr_q];

    // Buffer storage; data needs no reset, validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.lsq_opcode, bus.lsq_address, bus.lsq_data, bus.lsq_tag};
        end
    end

    // Circular buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!push && pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        dc_req  = 1'b0;
        cdb_req = 1'b0;
        dc_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                dc_req = 1'b1;
                if (bus.dc_ready) state_d = StWait;
            end
            StWait: begin
                if (bus.dc_done) state_d = dc_op_q ? StAck : StBcast;
            end
            StBcast: begin
                cdb_req = 1'b1;
                if (bus.cdb_grant) state_d = StAck;
            end
            StAck: begin
                dc_ack  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue/result registers and the sticky tag-mismatch flag
    always_ff @(posedge clk) begin
        if (reset) begin
            dc_op_q    <= 1'b0;
            dc_addr_q  <= '0;
            dc_data_q  <= '0;
            dc_tag_q   <= '0;
            cdb_data_q <= '0;
            cdb_tag_q  <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            if (pop) begin
                dc_op_q   <= head.op;
                dc_addr_q <= head.addr;
                dc_data_q <= head.data;
                dc_tag_q  <= head.tag;
            end
            // dc_done is only meaningful while an op is outstanding
            if (state_q == StWait && bus.dc_done) begin
                if (!dc_op_q) begin
                    cdb_data_q <= bus.dc_data_in;
                    cdb_tag_q  <= bus.dc_tag_in;
                end
                if (bus.dc_tag_in != dc_tag_q) tag_err_q <= 1'b1;
            end
        end
    end

    assign bus.dc_req     = dc_req;
    assign bus.dc_opcode  = dc_op_q;
    assign bus.dc_address = dc_addr_q;
    assign bus.dc_data    = dc_data_q;
    assign bus.dc_tag     = dc_tag_q;
    assign bus.dc_ack     = dc_ack;
    assign bus.cdb_req    = cdb_req;
    assign bus.cdb_data   = cdb_data_q;
    assign bus.cdb_tag    = cdb_tag_q;
    assign bus.tag_err    = tag_err_q;

`ifdef LS_ISSUE_STAT_EN
    logic [15:0] ld_count_q, st_count_q;

    // Saturating completion counters, bumped once per acknowledged op
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_count_q <= '0;
            st_count_q <= '0;
        end else if (state_q == StAck) begin
            if (!dc_op_q && ld_count_q != 16'hFFFF) ld_count_q <= ld_count_q + 16'd1;
            if (dc_op_q && st_count_q != 16'hFFFF)  st_count_q <= st_count_q + 16'd1;
        end
    end

    assign bus.ld_count = ld_count_q;
    assign bus.st_count = st_count_q;
`else
    assign bus.ld_count = '0;
    assign bus.st_count = '0;
`endif
endmodule
